// File: rtl/serial_frame_tx_if.sv
// ---------------------------------------------------------------------------
// serial_frame_tx_if
//
// Bundles the word-input handshake and the serial/status outputs of
// serial_frame_tx so the transmitter and its source connect with one port.
//
// Handshake: a word transfers on a rising CLK edge where VALID && READY are
// both high. DIN must be stable in that cycle only. VALID may drop at any
// time without a transfer, and VALID while READY is low is ignored.
//
// Signals:
//   DIN     [7:0]       word to send (source -> transmitter)
//   VALID               DIN holds a word (source -> transmitter)
//   READY               transmitter can accept a word (transmitter -> source)
//   DATAOUT             serial line (transmitter -> downstream)
//   BUSY                frame on the line (transmitter -> observer)
//   DONE                pulse in the final stop-bit cycle
//   FRAMES  [CNT_W-1:0] wrapping completed-frame count
//
// Modports:
//   master : the word source / observer side
//   slave  : the transmitter side
// ---------------------------------------------------------------------------
interface serial_frame_tx_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       DIN;
    logic             VALID;
    logic             READY;
    logic             DATAOUT;
    logic             BUSY;
    logic             DONE;
    logic [CNT_W-1:0] FRAMES;

    modport master (
        output DIN,
        output VALID,
        input  READY,
        input  DATAOUT,
        input  BUSY,
        input  DONE,
        input  FRAMES
    );

    modport slave (
        input  DIN,
        input  VALID,
        output READY,
        output DATAOUT,
        output BUSY,
        output DONE,
        output FRAMES
    );
endinterface

// File: rtl/serial_frame_tx.sv
// ---------------------------------------------------------------------------
// serial_frame_tx
//
// Serialises 8-bit words into frames for the downstream 9-bit serial capture
// register. Each frame is LEAD_BITS high bits, then the 8 data bits MSB
// first, then STOP_BITS low bits. At least one idle (low) cycle separates
// frames, so a frame period is 1 + LEAD_BITS + 8 + STOP_BITS cycles.
//
// Parameters:
//   LEAD_BITS  leading high bits per frame, 0..8 (0 skips the LEAD state)
//   STOP_BITS  low stop bits per frame, 1..4
//   CNT_W      width of the wrapping completed-frame counter
//
// Ports:
//   CLK        rising-edge clock
//   RESETN     asynchronous active-low reset; abandons any frame in flight
//   bus        serial_frame_tx_if.slave (DIN/VALID/READY handshake,
//              DATAOUT, BUSY, DONE, FRAMES)
//   state_dbg  current FSM state (IDLE=0, LEAD=1, DATA=2, STOP=3)
// ---------------------------------------------------------------------------
module serial_frame_tx #(
    parameter int LEAD_BITS = 3,
    parameter int STOP_BITS = 1,
    parameter int CNT_W     = 16
) (
    input  logic                     CLK,
    input  logic                     RESETN,
    serial_frame_tx_if.slave         bus,
    output logic [1:0]               state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LEAD = 2'd1,
        S_DATA = 2'd2,
        S_STOP = 2'd3
    } state_t;

    // Counter reload values. The counter counts down to 0 within each
    // state, so a state lasting N cycles is loaded with N-1.
    localparam logic [2:0] LEAD_LOAD = (LEAD_BITS == 0) ? 3'd0 : 3'(LEAD_BITS - 1);
    localparam logic [2:0] DATA_LOAD = 3'd7;
    localparam logic [2:0] STOP_LOAD = 3'(STOP_BITS - 1);

    state_t           state_q, state_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [2:0]       cnt_q,   cnt_d;
    logic             dout_q,  dout_d;
    logic             done_q,  done_d;
    logic [CNT_W-1:0] frames_q, frames_d;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= S_IDLE;
            shreg_q  <= 8'd0;
            cnt_q    <= 3'd0;
            dout_q   <= 1'b0;
            done_q   <= 1'b0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
            frames_q <= frames_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        frames_d = frames_q;
        dout_d   = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // READY is high only here, so VALID alone means accept.
                if (bus.VALID) begin
                    shreg_d = bus.DIN;
                    if (LEAD_BITS == 0) begin
                        state_d = S_DATA;
                        cnt_d   = DATA_LOAD;
                    end else begin
                        state_d = S_LEAD;
                        cnt_d   = LEAD_LOAD;
                    end
                end
            end

            S_LEAD: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_DATA;
                    cnt_d   = DATA_LOAD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            S_DATA: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_STOP;
                    cnt_d   = STOP_LOAD;
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                    // shreg[7] always holds the bit currently on the line
                    // during DATA, so shift only between data bits.
                    shreg_d = {shreg_q[6:0], 1'b0};
                end
            end

            S_STOP: begin
                if (cnt_q == 3'd0) begin
                    state_d  = S_IDLE;
                    frames_d = frames_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The line value is registered, so it is derived from the state the
        // FSM is moving into; this makes the first frame bit appear in the
        // cycle right after the accept edge.
        unique case (state_d)
            S_LEAD:  dout_d = 1'b1;
            S_DATA:  dout_d = shreg_d[7];
            default: dout_d = 1'b0;
        endcase

        done_d = (state_d == S_STOP) && (cnt_d == 3'd0);
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.READY   = (state_q == S_IDLE);
    assign bus.BUSY    = (state_q != S_IDLE);
    assign bus.DATAOUT = dout_q;
    assign bus.DONE    = done_q;
    assign bus.FRAMES  = frames_q;
    assign state_dbg   = state_q;

endmodule
